// File: rtl/mcyc_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, traps on bad ops.
module mcyc_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_ifetch,
    output logic             dm_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic             sign_ext,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [TW-1:0]    tmo_q, tmo_d, tmo_inc;
    logic             done, waiting, tmo_hit;

    // The IR holds the instruction after FETCH, so decode straight off it.
    logic is_r, is_add, is_sub, is_slt, is_jr, is_ralu;
    logic is_addi, is_xori, is_lw, is_sw, is_beq, is_bne;
    logic is_j, is_jal, is_alu_i, is_exec, taken;

    assign is_r     = (opcode == 6'h00);
    assign is_add   = is_r & (funct == 6'h20);
    assign is_sub   = is_r & (funct == 6'h22);
    assign is_slt   = is_r & (funct == 6'h2A);
    assign is_jr    = is_r & (funct == 6'h08);
    assign is_ralu  = is_add | is_sub | is_slt;
    assign is_addi  = (opcode == 6'h08);
    assign is_xori  = (opcode == 6'h0E);
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_beq   = (opcode == 6'h04);
    assign is_bne   = (opcode == 6'h05);
    assign is_j     = (opcode == 6'h02);
    assign is_jal   = (opcode == 6'h03);
    assign is_alu_i = is_addi | is_lw | is_sw;
    assign is_exec  = is_ralu | is_alu_i | is_xori | is_beq | is_bne;
    assign taken    = (is_beq & zero) | (is_bne & ~zero);

    // State, retired counter and memory-wait counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next state, completion and memory-wait timeout.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
        tmo_inc = tmo_q + TW'(1);
        tmo_hit = (TIMEOUT != 0) && waiting && (tmo_inc == TW'(TIMEOUT));
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (tmo_hit) state_d = S_TRAP;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_exec:                 state_d = S_EXEC;
                    is_j | is_jal | is_jr:   done    = 1'b1;
                    default:                 state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                if (is_ralu | is_addi | is_xori) state_d = S_WB;
                else if (is_lw | is_sw)          state_d = S_MEM;
                else if (is_beq | is_bne)        done    = 1'b1;
                else                             state_d = S_TRAP;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_sw) done    = 1'b1;
                    else       state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB:    done    = 1'b1;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (done) state_d = run ? S_FETCH : S_IDLE;
        tmo_d     = (waiting && (state_d == state_q)) ? tmo_inc : '0;
        retired_d = retired_q + CNT_W'(done);
    end

    // Datapath strobes and selects for the current state.
    always_comb begin
        mem_req    = 1'b0;
        mem_ifetch = 1'b0;
        dm_we      = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        reg_we     = 1'b0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        alu_src    = 1'b0;
        sign_ext   = 1'b0;
        alu_op     = 3'b000;
        trap       = 1'b0;
        if ((state_q == S_EXEC) || (state_q == S_MEM)) begin
            unique case (1'b1)
                is_add:   alu_op = 3'b000;
                is_sub:   alu_op = 3'b001;
                is_slt:   alu_op = 3'b011;
                is_alu_i: begin
                    alu_src  = 1'b1;
                    sign_ext = 1'b1;
                end
                is_xori: begin
                    alu_src = 1'b1;
                    alu_op  = 3'b010;
                end
                is_beq | is_bne: alu_op = 3'b001;
                default: alu_op = 3'b000;
            endcase
        end
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                ir_we      = mem_ready;
                pc_we      = mem_ready;
            end
            S_DECODE: begin
                if (is_jr) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd3;
                end else if (is_j | is_jal) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd2;
                    if (is_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wb_sel  = 2'd2;
                    end
                end
            end
            S_EXEC: begin
                if (taken) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                dm_we   = is_sw;
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = is_ralu ? 2'd1 : 2'd0;
                wb_sel  = is_lw ? 2'd1 : 2'd0;
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b0;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Bench for mcyc_ctrl: directed cases plus random instruction stream
// checked against per-instruction expectations derived from the ISA rules.
module tb_mcyc_ctrl;

    localparam int CW = 8;

    localparam int K_ADD  = 0;
    localparam int K_SUB  = 1;
    localparam int K_SLT  = 2;
    localparam int K_JR   = 3;
    localparam int K_ADDI = 4;
    localparam int K_XORI = 5;
    localparam int K_LW   = 6;
    localparam int K_SW   = 7;
    localparam int K_BEQ  = 8;
    localparam int K_BNE  = 9;
    localparam int K_J    = 10;
    localparam int K_JAL  = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          run = 1'b0;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_ifetch, dm_we, ir_we, pc_we;
    logic [1:0]    pc_src, reg_dst, wb_sel;
    logic          reg_we, alu_src, sign_ext, trap;
    logic [2:0]    alu_op, state;
    logic [CW-1:0] retired;

    int total = 0;
    int bad = 0;
    logic [CW-1:0] mdl_ret = '0;
    bit mdl_idle = 1'b1;

    mcyc_ctrl #(.CNT_W(CW), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_ifetch(mem_ifetch), .dm_we(dm_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src(alu_src),
        .sign_ext(sign_ext), .alu_op(alu_op), .state(state),
        .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] op_of(input int k);
        case (k)
            K_ADDI:  return 6'h08;
            K_XORI:  return 6'h0E;
            K_LW:    return 6'h23;
            K_SW:    return 6'h2B;
            K_BEQ:   return 6'h04;
            K_BNE:   return 6'h05;
            K_J:     return 6'h02;
            K_JAL:   return 6'h03;
            default: return 6'h00;
        endcase
    endfunction

    function automatic bit is_rk(input int k);
        return k <= K_JR;
    endfunction

    function automatic bit is_jmp(input int k);
        return (k == K_JR) || (k == K_J) || (k == K_JAL);
    endfunction

    function automatic bit is_mem(input int k);
        return (k == K_LW) || (k == K_SW);
    endfunction

    function automatic bit has_wb(input int k);
        return (k <= K_SLT) || (k == K_ADDI) || (k == K_XORI) || (k == K_LW);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        run = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_strobes", {mem_req, dm_we, ir_we, pc_we, reg_we}, 0);
        chk("rst_sel", {pc_src, reg_dst, wb_sel, alu_op}, 0);
        tick();
        reset_n = 1'b1;
        mdl_ret = '0;
        mdl_idle = 1'b1;
    endtask

    // Runs one instruction; called aligned 1 time unit after a posedge.
    task automatic run_instr(input int k, input logic z, input int wf,
                             input int wm, input logic run_after);
        logic [2:0] seq[$];
        int len, wl, irw, pcw, regw, dmw, mreq, both, trp;
        logic [1:0] lsrc, rd, ws;
        logic [4:0] aluv;
        bit tk;
        int xsrc, xop, xsx;
        seq = {};
        if (mdl_idle) seq.push_back(3'd0);
        repeat (wf + 1) seq.push_back(3'd1);
        seq.push_back(3'd2);
        if (!is_jmp(k)) seq.push_back(3'd3);
        if (is_mem(k)) repeat (wm + 1) seq.push_back(3'd4);
        if (has_wb(k)) seq.push_back(3'd5);
        len = seq.size();
        opcode = op_of(k);
        case (k)
            K_ADD:   funct = 6'h20;
            K_SUB:   funct = 6'h22;
            K_SLT:   funct = 6'h2A;
            K_JR:    funct = 6'h08;
            default: funct = 6'($urandom);
        endcase
        zero = z;
        wl = wf;
        irw = 0; pcw = 0; regw = 0; dmw = 0; mreq = 0; both = 0; trp = 0;
        lsrc = 0; rd = 0; ws = 0; aluv = '1;
        for (int c = 0; c < len; c++) begin
            if (c == len - 1)                 run = run_after;
            else if (seq[c] == 3'd0)          run = 1'b1;
            else                              run = 1'($urandom);
            if (seq[c] == 3'd1 || seq[c] == 3'd4) begin
                if (wl > 0) begin
                    mem_ready = 1'b0;
                    wl--;
                end else begin
                    mem_ready = 1'b1;
                    wl = wm;
                end
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            chk("state_seq", 32'(state), 32'(seq[c]));
            if (seq[c] == 3'd0) chk("idle_mem_req", 32'(mem_req), 0);
            irw  += int'(ir_we);
            pcw  += int'(pc_we);
            regw += int'(reg_we);
            dmw  += int'(dm_we);
            mreq += int'(mem_req);
            both += int'(pc_we & reg_we);
            trp  += int'(trap);
            if (pc_we) lsrc = pc_src;
            if (reg_we) begin
                rd = reg_dst;
                ws = wb_sel;
            end
            if (seq[c] == 3'd3) aluv = {alu_src, sign_ext, alu_op};
            tick();
        end
        tk = ((k == K_BEQ) && z) || ((k == K_BNE) && !z);
        mdl_ret = mdl_ret + 1'b1;
        mdl_idle = !run_after;
        chk("end_state", 32'(state), run_after ? 1 : 0);
        chk("retired", 32'(retired), 32'(mdl_ret));
        chk("ir_we_cnt", irw, 1);
        chk("mem_req_cnt", mreq, (wf + 1) + (is_mem(k) ? wm + 1 : 0));
        chk("pc_we_cnt", pcw, 1 + ((is_jmp(k) || tk) ? 1 : 0));
        chk("pc_src", 32'(lsrc),
            (k == K_JR) ? 3 : (k == K_J || k == K_JAL) ? 2 : tk ? 1 : 0);
        chk("reg_we_cnt", regw, (has_wb(k) || k == K_JAL) ? 1 : 0);
        chk("reg_dst", 32'(rd), (k <= K_SLT) ? 1 : (k == K_JAL) ? 2 : 0);
        chk("wb_sel", 32'(ws), (k == K_LW) ? 1 : (k == K_JAL) ? 2 : 0);
        chk("dm_we_cnt", dmw, (k == K_SW) ? wm + 1 : 0);
        chk("jal_same_cycle", both, (k == K_JAL) ? 1 : 0);
        chk("trap_low", trp, 0);
        if (!is_jmp(k)) begin
            xsrc = (k == K_ADDI || k == K_XORI || is_mem(k)) ? 1 : 0;
            xsx  = (k == K_ADDI || is_mem(k)) ? 1 : 0;
            xop  = (k == K_SUB || k == K_BEQ || k == K_BNE) ? 1 :
                   (k == K_SLT) ? 3 : (k == K_XORI) ? 2 : 0;
            chk("alu_ctrl", 32'(aluv), (xsrc << 4) | (xsx << 3) | xop);
        end
    endtask

    initial begin
        #2;
        do_reset();

        run_instr(K_ADDI, 1'b0, 0, 0, 1'b1);
        run_instr(K_LW,   1'b0, 0, 3, 1'b1);
        run_instr(K_BEQ,  1'b1, 0, 0, 1'b1);
        run_instr(K_BEQ,  1'b0, 0, 0, 1'b1);
        run_instr(K_BNE,  1'b0, 0, 0, 1'b1);
        run_instr(K_JAL,  1'b0, 0, 0, 1'b1);
        run_instr(K_SW,   1'b0, 1, 2, 1'b0);
        run_instr(K_ADD,  1'b0, 0, 0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            run_instr(int'($urandom_range(0, 11)), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) != 0));
        end

        // illegal opcode traps and leaves retired alone
        do_reset();
        run_instr(K_J, 1'b0, 0, 0, 1'b1);
        opcode = 6'h3F;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("illop_state", 32'(state), 7);
        chk("illop_trap", 32'(trap), 1);
        chk("illop_retired", 32'(retired), 32'(mdl_ret));
        chk("illop_strobes", {mem_req, dm_we, ir_we, pc_we, reg_we}, 0);
        tick();
        chk("illop_sticky", 32'(state), 7);

        // illegal funct under opcode 0
        do_reset();
        run_instr(K_SW, 1'b0, 0, 0, 1'b1);
        opcode = 6'h00;
        funct = 6'h3F;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("illfn_state", 32'(state), 7);
        chk("illfn_retired", 32'(retired), 32'(mdl_ret));

        // fetch timeout after four unanswered cycles
        do_reset();
        run = 1'b1;
        opcode = 6'h02;
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tmo_wait", 32'(state), 1);
            tick();
        end
        chk("tmo_state", 32'(state), 7);
        chk("tmo_trap", 32'(trap), 1);
        chk("tmo_retired", 32'(retired), 0);
        chk("tmo_mem_req", 32'(mem_req), 0);

        // asynchronous reset in the middle of a load's MEM phase
        do_reset();
        run = 1'b1;
        opcode = 6'h23;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("mid_mem_state", 32'(state), 4);
        chk("mid_mem_req", 32'(mem_req), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_strobes", {mem_req, dm_we, ir_we, pc_we, reg_we}, 0);
        chk("arst_sel", {alu_src, sign_ext, alu_op, wb_sel, reg_dst}, 0);
        chk("arst_retired", 32'(retired), 0);
        tick();
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
